// File: rtl/branch_predictor_ctrl.sv
// Fetch-side branch predictor control: clears the table RAM after reset, does tag
// compare and counter decode on lookups, and turns resolved branches into table writes.
module branch_predictor_ctrl #(
  parameter int BRANCH_TABLE_ENTRIES = 512,
  parameter int TAG_W = 16,
  localparam int IDX_W = $clog2(BRANCH_TABLE_ENTRIES),
  localparam int ENTRY_W = 1 + TAG_W + 30 + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [31:0]        fetch_pc,
  output logic               predict_valid,
  output logic               predict_taken,
  output logic [31:0]        predict_target,
  output logic               predict_hit,
  output logic [1:0]         predict_counter,
  output logic               init_done,
  input  logic               update_en,
  input  logic [31:0]        update_pc,
  input  logic               update_taken,
  input  logic [31:0]        update_target,
  input  logic               update_hit,
  input  logic [1:0]         update_counter,
  output logic [IDX_W-1:0]   ram_read_addr,
  output logic               ram_read_en,
  input  logic [ENTRY_W-1:0] ram_read_data,
  output logic [IDX_W-1:0]   ram_write_addr,
  output logic               ram_write_en,
  output logic [ENTRY_W-1:0] ram_write_data
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [IDX_W:0] SWEEP_LAST = (IDX_W + 1)'(BRANCH_TABLE_ENTRIES - 1);

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  state_t             state;
  logic [IDX_W:0]     sweep_cnt;
  logic               in_run;

  logic               collide_p0;
  logic [IDX_W-1:0]   upd_idx_p0;
  logic               upd_write_p0;
  logic [1:0]         upd_cnt_p0;
  logic [ENTRY_W-1:0] upd_entry_p0;

  logic               vld_p1;
  logic               col_p1;
  logic [TAG_W-1:0]   tag_p1;
  logic [ENTRY_W-1:0] col_data_p1;
  logic [ENTRY_W-1:0] entry_p1;
  logic               hit_p1;

  logic               unused_bits;
  assign unused_bits = ^{fetch_pc, update_pc, update_target[1:0]};

  // p0: lookup issue, collision detect, update entry formation
  assign in_run        = (state == S_RUN);
  assign ram_read_en   = in_run & fetch_en;
  assign ram_read_addr = in_run ? fetch_pc[2 +: IDX_W] : '0;
  // A write landing in the same cycle as the read may not be visible in the RAM output.
  assign collide_p0    = ram_write_en & ram_read_en & (ram_write_addr == ram_read_addr);

  assign upd_idx_p0   = update_pc[2 +: IDX_W];
  assign upd_write_p0 = update_en & (update_hit | update_taken);
  assign upd_cnt_p0   = !update_hit   ? 2'b10 :
                        update_taken  ? sat_inc(update_counter) : sat_dec(update_counter);
  assign upd_entry_p0 = {1'b1, update_pc[2+IDX_W +: TAG_W], update_target[31:2], upd_cnt_p0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_INIT;
      sweep_cnt      <= '0;
      init_done      <= 1'b0;
      ram_write_en   <= 1'b0;
      ram_write_addr <= '0;
      ram_write_data <= '0;
      vld_p1         <= 1'b0;
      col_p1         <= 1'b0;
    end else begin
      vld_p1 <= ram_read_en;
      col_p1 <= collide_p0;
      case (state)
        S_INIT: begin
          ram_write_en   <= 1'b1;
          ram_write_addr <= sweep_cnt[IDX_W-1:0];
          ram_write_data <= '0;
          sweep_cnt      <= sweep_cnt + (IDX_W + 1)'(1);
          if (sweep_cnt == SWEEP_LAST) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          ram_write_en   <= upd_write_p0;
          ram_write_addr <= upd_idx_p0;
          ram_write_data <= upd_entry_p0;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    tag_p1      <= fetch_pc[2+IDX_W +: TAG_W];
    col_data_p1 <= ram_write_data;
  end

  // p1: table entry returned, tag compare and counter decode
  assign entry_p1 = col_p1 ? col_data_p1 : ram_read_data;
  assign hit_p1   = vld_p1 & entry_p1[ENTRY_W-1] & (entry_p1[ENTRY_W-2 -: TAG_W] == tag_p1);

  assign predict_valid   = vld_p1;
  assign predict_hit     = hit_p1;
  assign predict_taken   = hit_p1 & entry_p1[1];
  assign predict_target  = vld_p1 ? {entry_p1[31:2], 2'b00} : '0;
  assign predict_counter = vld_p1 ? entry_p1[1:0] : 2'b00;

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Scoreboard bench for branch_predictor_ctrl with a read-first table RAM model.
module tb_branch_predictor_ctrl;

  localparam int N       = 512;
  localparam int IDX_W   = 9;
  localparam int TAG_W   = 16;
  localparam int ENTRY_W = 49;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  cnt;
  } pred_t;

  typedef struct packed {
    logic [IDX_W-1:0]   addr;
    logic [ENTRY_W-1:0] data;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fetch_en = 1'b0;
  logic [31:0]        fetch_pc = '0;
  logic               predict_valid, predict_taken, predict_hit;
  logic [31:0]        predict_target;
  logic [1:0]         predict_counter;
  logic               init_done;
  logic               update_en = 1'b0;
  logic [31:0]        update_pc = '0;
  logic               update_taken = 1'b0;
  logic [31:0]        update_target = '0;
  logic               update_hit = 1'b0;
  logic [1:0]         update_counter = '0;
  logic [IDX_W-1:0]   ram_read_addr, ram_write_addr;
  logic               ram_read_en, ram_write_en;
  logic [ENTRY_W-1:0] ram_read_data = '0;
  logic [ENTRY_W-1:0] ram_write_data;

  logic [ENTRY_W-1:0] mem [N];

  pred_t exp_pred_q[$], got_pred_q[$];
  wr_t   exp_wr_q[$],   got_wr_q[$];
  int    n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  branch_predictor_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .predict_valid(predict_valid), .predict_taken(predict_taken),
    .predict_target(predict_target), .predict_hit(predict_hit),
    .predict_counter(predict_counter), .init_done(init_done),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_hit(update_hit), .update_counter(update_counter),
    .ram_read_addr(ram_read_addr), .ram_read_en(ram_read_en), .ram_read_data(ram_read_data),
    .ram_write_addr(ram_write_addr), .ram_write_en(ram_write_en), .ram_write_data(ram_write_data)
  );

  // Read-first RAM: a same-cycle write is not visible to the read.
  always @(posedge clk) begin
    if (ram_read_en)  ram_read_data <= mem[ram_read_addr];
    if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
  end

  always @(negedge clk) begin
    if (predict_valid) got_pred_q.push_back({predict_hit, predict_taken, predict_target, predict_counter});
    if (ram_write_en)  got_wr_q.push_back({ram_write_addr, ram_write_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [31:0] pc, input logic [31:0] tgt,
                                                   input logic [1:0] c);
    return {1'b1, pc[2+IDX_W +: TAG_W], tgt[31:2], c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_en  = 1'b0;
    update_en = 1'b0;
  endtask

  task automatic put_fetch(input logic [31:0] pc, input logic hit, input logic taken,
                           input logic [31:0] tgt, input logic [1:0] c);
    fetch_en = 1'b1;
    fetch_pc = pc;
    exp_pred_q.push_back({hit, taken, tgt, c});
  endtask

  task automatic put_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic hit, input logic [1:0] cnt, input logic wr,
                            input logic [1:0] wr_cnt);
    update_en      = 1'b1;
    update_pc      = pc;
    update_taken   = taken;
    update_target  = tgt;
    update_hit     = hit;
    update_counter = cnt;
    if (wr) exp_wr_q.push_back({pc[2 +: IDX_W], mk_entry(pc, tgt, wr_cnt)});
  endtask

  task automatic test_reset();
    int cyc;
    int first_bad;
    bit saw_read;
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({predict_valid, predict_taken, predict_hit, predict_target, predict_counter, init_done,
         ram_read_en, ram_write_en, ram_read_addr, ram_write_addr, ram_write_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b init_done=%b rd_en=%b wr_en=%b wr_addr=%0d wr_data=%h, required all 0",
               predict_valid, init_done, ram_read_en, ram_write_en, ram_write_addr, ram_write_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fetch_en = 1'b1; fetch_pc = 32'h1000;
    put_update(32'h40, 1'b1, 32'h5000, 1'b0, 2'b00, 1'b0, 2'b00);
    cyc = 0;
    saw_read = 1'b0;
    while (!init_done && cyc < 2000) begin
      tick();
      cyc++;
      if (ram_read_en) saw_read = 1'b1;
      if (cyc == 100) idle();
    end
    n_vec++;
    if (saw_read) begin
      n_err++;
      $display("FAIL init_read: ram_read_en=1 seen during INIT, required 0");
    end
    n_vec++;
    if (cyc != N) begin
      n_err++;
      $display("FAIL init_done_cycle: rose after %0d cycles, required %0d", cyc, N);
    end
    tick();
    n_vec++;
    if (got_pred_q.size() != 0) begin
      n_err++;
      $display("FAIL init_predict: %0d predictions during INIT, required 0", got_pred_q.size());
    end
    first_bad = -1;
    if (got_wr_q.size() == N)
      foreach (got_wr_q[i])
        if (first_bad < 0 && (got_wr_q[i].addr !== IDX_W'(i) || got_wr_q[i].data !== '0)) first_bad = i;
    n_vec++;
    if (got_wr_q.size() != N || first_bad >= 0) begin
      n_err++;
      $display("FAIL init_sweep: %0d writes, first bad position %0d, required %0d zero writes to 0..%0d in order",
               got_wr_q.size(), first_bad, N, N - 1);
    end
    got_wr_q.delete();
    got_pred_q.delete();
  endtask

  task automatic test_cold_lookup();
    pred_t e, g;
    put_fetch(32'h0000_1000, 1'b0, 1'b0, 32'h0, 2'b00);
    tick(); idle(); tick();
    while (exp_pred_q.size() > 0) begin
      e = exp_pred_q.pop_front();
      n_vec++;
      if (got_pred_q.size() == 0) begin
        n_err++;
        $display("FAIL cold_pred: no prediction, expected %h", e);
      end else begin
        g = got_pred_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL cold_pred: got hit=%b taken=%b target=%h counter=%b, expected hit=%b taken=%b target=%h counter=%b",
                   g.hit, g.taken, g.target, g.cnt, e.hit, e.taken, e.target, e.cnt);
        end
      end
    end
  endtask

  task automatic test_allocate_hit();
    pred_t e, g;
    wr_t   ew, gw;
    put_update(32'h1000, 1'b1, 32'h2000, 1'b0, 2'b00, 1'b1, 2'b10);
    tick(); idle(); tick();
    put_fetch(32'h1000, 1'b1, 1'b1, 32'h2000, 2'b10);
    tick(); idle(); tick();
    while (exp_wr_q.size() > 0) begin
      ew = exp_wr_q.pop_front();
      n_vec++;
      if (got_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL alloc_write: no write, expected addr=%0d data=%h", ew.addr, ew.data);
      end else begin
        gw = got_wr_q.pop_front();
        if (gw !== ew) begin
          n_err++;
          $display("FAIL alloc_write: got addr=%0d data=%h, expected addr=%0d data=%h", gw.addr, gw.data, ew.addr, ew.data);
        end
      end
    end
    while (exp_pred_q.size() > 0) begin
      e = exp_pred_q.pop_front();
      n_vec++;
      if (got_pred_q.size() == 0) begin
        n_err++;
        $display("FAIL alloc_pred: no prediction, expected %h", e);
      end else begin
        g = got_pred_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL alloc_pred: got hit=%b taken=%b target=%h counter=%b, expected hit=%b taken=%b target=%h counter=%b",
                   g.hit, g.taken, g.target, g.cnt, e.hit, e.taken, e.target, e.cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back_saturation();
    pred_t e, g;
    wr_t   ew, gw;
    put_update(32'h1000, 1'b0, 32'h2000, 1'b1, 2'b10, 1'b1, 2'b01); tick();
    put_update(32'h1000, 1'b0, 32'h2000, 1'b1, 2'b01, 1'b1, 2'b00); tick();
    put_update(32'h1000, 1'b0, 32'h2000, 1'b1, 2'b00, 1'b1, 2'b00); tick();
    put_update(32'h1000, 1'b1, 32'h2000, 1'b1, 2'b11, 1'b1, 2'b11); tick();
    put_update(32'h1000, 1'b1, 32'h2000, 1'b1, 2'b11, 1'b1, 2'b11); tick();
    put_update(32'h1000, 1'b0, 32'h9000, 1'b0, 2'b00, 1'b0, 2'b00); tick();
    idle(); tick();
    put_fetch(32'h1000, 1'b1, 1'b1, 32'h2000, 2'b11);
    tick(); idle(); tick();
    while (exp_wr_q.size() > 0) begin
      ew = exp_wr_q.pop_front();
      n_vec++;
      if (got_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL sat_write: no write, expected addr=%0d data=%h", ew.addr, ew.data);
      end else begin
        gw = got_wr_q.pop_front();
        if (gw !== ew) begin
          n_err++;
          $display("FAIL sat_write: got addr=%0d data=%h, expected addr=%0d data=%h", gw.addr, gw.data, ew.addr, ew.data);
        end
      end
    end
    n_vec++;
    if (got_wr_q.size() != 0) begin
      n_err++;
      $display("FAIL miss_not_taken_write: %0d extra writes, required 0", got_wr_q.size());
      got_wr_q.delete();
    end
    while (exp_pred_q.size() > 0) begin
      e = exp_pred_q.pop_front();
      n_vec++;
      if (got_pred_q.size() == 0) begin
        n_err++;
        $display("FAIL sat_pred: no prediction, expected %h", e);
      end else begin
        g = got_pred_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL sat_pred: got hit=%b taken=%b target=%h counter=%b, expected hit=%b taken=%b target=%h counter=%b",
                   g.hit, g.taken, g.target, g.cnt, e.hit, e.taken, e.target, e.cnt);
        end
      end
    end
  endtask

  task automatic test_tag_alias();
    pred_t e, g;
    put_fetch(32'h1000 + (32'd512 << 2), 1'b0, 1'b0, 32'h2000, 2'b11);
    tick(); idle(); tick();
    while (exp_pred_q.size() > 0) begin
      e = exp_pred_q.pop_front();
      n_vec++;
      if (got_pred_q.size() == 0) begin
        n_err++;
        $display("FAIL alias_pred: no prediction, expected %h", e);
      end else begin
        g = got_pred_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL alias_pred: got hit=%b taken=%b target=%h counter=%b, expected hit=%b taken=%b target=%h counter=%b",
                   g.hit, g.taken, g.target, g.cnt, e.hit, e.taken, e.target, e.cnt);
        end
      end
    end
  endtask

  task automatic test_collision();
    pred_t e, g;
    wr_t   ew, gw;
    put_update(32'h14, 1'b1, 32'h3000, 1'b0, 2'b00, 1'b1, 2'b10);
    put_fetch(32'h14, 1'b0, 1'b0, 32'h0, 2'b00);
    tick();
    update_en = 1'b0;
    put_fetch(32'h14, 1'b1, 1'b1, 32'h3000, 2'b10);
    tick();
    put_fetch(32'h14, 1'b1, 1'b1, 32'h3000, 2'b10);
    tick(); idle(); tick();
    while (exp_wr_q.size() > 0) begin
      ew = exp_wr_q.pop_front();
      n_vec++;
      if (got_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL collide_write: no write, expected addr=%0d data=%h", ew.addr, ew.data);
      end else begin
        gw = got_wr_q.pop_front();
        if (gw !== ew) begin
          n_err++;
          $display("FAIL collide_write: got addr=%0d data=%h, expected addr=%0d data=%h", gw.addr, gw.data, ew.addr, ew.data);
        end
      end
    end
    while (exp_pred_q.size() > 0) begin
      e = exp_pred_q.pop_front();
      n_vec++;
      if (got_pred_q.size() == 0) begin
        n_err++;
        $display("FAIL collide_pred: no prediction, expected %h", e);
      end else begin
        g = got_pred_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL collide_pred: got hit=%b taken=%b target=%h counter=%b, expected hit=%b taken=%b target=%h counter=%b",
                   g.hit, g.taken, g.target, g.cnt, e.hit, e.taken, e.target, e.cnt);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int first_bad;
    fetch_en = 1'b1; fetch_pc = 32'h1000;
    put_update(32'h24, 1'b1, 32'h7000, 1'b0, 2'b00, 1'b0, 2'b00);
    tick();
    n_vec++;
    if (!(predict_valid && ram_write_en)) begin
      n_err++;
      $display("FAIL run_pending: valid=%b wr_en=%b, required 1 and 1", predict_valid, ram_write_en);
    end
    rst = 1'b0;
    idle();
    #1;
    n_vec++;
    if ({predict_valid, ram_write_en, init_done} !== 3'b000) begin
      n_err++;
      $display("FAIL run_reset_drop: valid=%b wr_en=%b init_done=%b, required 0 0 0",
               predict_valid, ram_write_en, init_done);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (201) tick();
    n_vec++;
    if (!(ram_write_en && ram_write_addr == 9'd200 && !init_done)) begin
      n_err++;
      $display("FAIL sweep_200: wr_en=%b addr=%0d init_done=%b, required 1 200 0", ram_write_en, ram_write_addr, init_done);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({ram_write_en, init_done, ram_write_addr} !== '0) begin
      n_err++;
      $display("FAIL init_reset: wr_en=%b init_done=%b addr=%0d, required 0 0 0", ram_write_en, init_done, ram_write_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    got_wr_q.delete();
    got_pred_q.delete();
    cyc = 0;
    while (!init_done && cyc < 2000) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != N) begin
      n_err++;
      $display("FAIL restart_init_done: rose after %0d cycles, required %0d", cyc, N);
    end
    tick();
    first_bad = -1;
    if (got_wr_q.size() == N)
      foreach (got_wr_q[i])
        if (first_bad < 0 && (got_wr_q[i].addr !== IDX_W'(i) || got_wr_q[i].data !== '0)) first_bad = i;
    n_vec++;
    if (got_wr_q.size() != N || first_bad >= 0) begin
      n_err++;
      $display("FAIL restart_sweep: %0d writes, first bad position %0d, required %0d zero writes from index 0",
               got_wr_q.size(), first_bad, N);
    end
    got_wr_q.delete();
  endtask

  initial begin
    test_reset();
    test_cold_lookup();
    test_allocate_hit();
    test_back_to_back_saturation();
    test_tag_alias();
    test_collision();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
